// File: rtl/vx_mem_lat_monitor_pkg.sv
// Shared types and default widths for the memory load-latency monitor.
// Defaults track the pipeline perf CSR width and the per-entry age counter.
package vx_mem_lat_monitor_pkg;

  localparam int LAT_TAG_ID_BITS = 4;
  localparam int LAT_AGE_BITS    = 16;
  localparam int LAT_CTR_BITS    = 44;

  typedef struct packed {
    logic                    valid;
    logic [LAT_AGE_BITS-1:0] age;
  } lat_entry_t;

endpackage

// File: rtl/vx_lat_age_table.sv
// Per-tag outstanding-read table: one {valid, age} entry per tag ID, ages
// saturate-increment every cycle; exposes status/age of both addressed tags.
module vx_lat_age_table
  import vx_mem_lat_monitor_pkg::*;
#(
  parameter int TAG_ID_BITS = LAT_TAG_ID_BITS,
  parameter int AGE_BITS    = LAT_AGE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc,
  input  logic [TAG_ID_BITS-1:0] alloc_tag,
  input  logic                   retire,
  input  logic [TAG_ID_BITS-1:0] retire_tag,
  output logic                   alloc_valid,
  output logic                   retire_valid,
  output logic [AGE_BITS-1:0]    retire_age
);

  localparam int DEPTH = 1 << TAG_ID_BITS;
  localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};
  localparam logic [AGE_BITS-1:0] AGE_ONE = {{(AGE_BITS-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]    valid_r;
  logic [AGE_BITS-1:0] age_r [DEPTH];

  assign alloc_valid  = valid_r[alloc_tag];
  assign retire_valid = valid_r[retire_tag];
  assign retire_age   = age_r[retire_tag];

  // Entry update: allocation wins over retire on the same tag, which gives
  // retire-then-reallocate since the retired age was already read out above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= {AGE_BITS{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && (alloc_tag == i[TAG_ID_BITS-1:0])) begin
          valid_r[i] <= 1'b1;
          age_r[i]   <= AGE_ONE;
        end else if (retire && valid_r[i] && (retire_tag == i[TAG_ID_BITS-1:0])) begin
          valid_r[i] <= 1'b0;
          age_r[i]   <= {AGE_BITS{1'b0}};
        end else if (valid_r[i] && (age_r[i] != AGE_MAX)) begin
          age_r[i] <= age_r[i] + AGE_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/vx_mem_lat_monitor.sv
// Non-intrusive load-latency monitor: snoops the core-to-dcache handshakes and
// accumulates read count, latency sum/max, pending count and sticky errors.
module vx_mem_lat_monitor
  import vx_mem_lat_monitor_pkg::*;
#(
  parameter int TAG_ID_BITS = LAT_TAG_ID_BITS,
  parameter int AGE_BITS    = LAT_AGE_BITS,
  parameter int CTR_BITS    = LAT_CTR_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   req_valid,
  input  logic                   req_ready,
  input  logic                   req_rw,
  input  logic [TAG_ID_BITS-1:0] req_tag_id,
  input  logic                   rsp_valid,
  input  logic                   rsp_ready,
  input  logic [TAG_ID_BITS-1:0] rsp_tag_id,
  output logic [CTR_BITS-1:0]    perf_reads,
  output logic [CTR_BITS-1:0]    perf_lat_sum,
  output logic [AGE_BITS-1:0]    perf_lat_max,
  output logic [TAG_ID_BITS:0]   perf_pending,
  output logic                   err_dup_tag,
  output logic                   err_orphan_rsp
);

  localparam logic [CTR_BITS-1:0]  CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [TAG_ID_BITS:0] PEND_ONE = {{TAG_ID_BITS{1'b0}}, 1'b1};

  logic                rd_fire_s;
  logic                rsp_fire_s;
  logic                alloc_valid_s;
  logic                retire_valid_s;
  logic [AGE_BITS-1:0] retire_age_s;
  logic                rsp_hit_s;
  logic                same_tag_s;
  logic                dup_s;
  logic                orphan_s;
  logic                pend_inc_s;

  assign rd_fire_s  = req_valid & req_ready & ~req_rw;
  assign rsp_fire_s = rsp_valid & rsp_ready;

  vx_lat_age_table #(
    .TAG_ID_BITS (TAG_ID_BITS),
    .AGE_BITS    (AGE_BITS)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .alloc        (rd_fire_s),
    .alloc_tag    (req_tag_id),
    .retire       (rsp_fire_s),
    .retire_tag   (rsp_tag_id),
    .alloc_valid  (alloc_valid_s),
    .retire_valid (retire_valid_s),
    .retire_age   (retire_age_s)
  );

  // A same-tag retire frees the slot before the new read lands in it.
  assign rsp_hit_s  = rsp_fire_s & retire_valid_s;
  assign same_tag_s = rd_fire_s & rsp_hit_s & (req_tag_id == rsp_tag_id);
  assign dup_s      = rd_fire_s & alloc_valid_s & ~same_tag_s;
  assign orphan_s   = rsp_fire_s & ~retire_valid_s;
  assign pend_inc_s = rd_fire_s & (~alloc_valid_s | same_tag_s);

  // Outstanding-read count; survives clear, only reset zeroes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_pending <= {(TAG_ID_BITS+1){1'b0}};
    end else begin
      case ({pend_inc_s, rsp_hit_s})
        2'b10:   perf_pending <= perf_pending + PEND_ONE;
        2'b01:   perf_pending <= perf_pending - PEND_ONE;
        default: perf_pending <= perf_pending;
      endcase
    end
  end

  // Perf counters, worst-case latency and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads     <= {CTR_BITS{1'b0}};
      perf_lat_sum   <= {CTR_BITS{1'b0}};
      perf_lat_max   <= {AGE_BITS{1'b0}};
      err_dup_tag    <= 1'b0;
      err_orphan_rsp <= 1'b0;
    end else if (clear) begin
      perf_reads     <= {CTR_BITS{1'b0}};
      perf_lat_sum   <= {CTR_BITS{1'b0}};
      perf_lat_max   <= {AGE_BITS{1'b0}};
      err_dup_tag    <= 1'b0;
      err_orphan_rsp <= 1'b0;
    end else begin
      if (rd_fire_s) begin
        perf_reads <= perf_reads + CTR_ONE;
      end
      if (rsp_hit_s) begin
        perf_lat_sum <= perf_lat_sum + CTR_BITS'(retire_age_s);
        if (retire_age_s > perf_lat_max) begin
          perf_lat_max <= retire_age_s;
        end
      end
      if (dup_s) begin
        err_dup_tag <= 1'b1;
      end
      if (orphan_s) begin
        err_orphan_rsp <= 1'b1;
      end
    end
  end

endmodule
